// File: rtl/mdu_seq.sv
// mdu_seq: sequencer and result stage for the RV32M multiply/divide unit (EXE).
//   Multiplies, divide-by-zero and signed-overflow cases complete in the same
//   cycle they are presented. A real divide pulses the signed or unsigned
//   divider start, stalls the pipeline until div_ok (or a wait limit), then
//   presents the captured result for one DONE cycle.
// Ports:
//   clk, clrn                 clock, async active-low reset
//   rv32m, func3, a, b        EXE instruction and operands (held while stall)
//   cancel                    pipeline flush, kills the in-flight op
//   c_mul..c_mulu             combinational multiplier results
//   c_div..c_remu, div_ok     divider results, valid while div_ok
//   start_sdivide/udivide     registered one-cycle divider start pulses
//   stall                     freeze IF/ID/EXE
//   result, wb_valid          write-back value and strobe
//   timeout_err               sticky: a divide ran out of wait cycles
module mdu_seq #(
  parameter int MAX_WAIT = 40,
  parameter int CW       = 6
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        rv32m,
  input  logic [2:0]  func3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic [31:0] c_mul,
  input  logic [31:0] c_mulh,
  input  logic [31:0] c_mulhsu,
  input  logic [31:0] c_mulu,
  input  logic [31:0] c_div,
  input  logic [31:0] c_divu,
  input  logic [31:0] c_rem,
  input  logic [31:0] c_remu,
  input  logic        div_ok,
  output logic        start_sdivide,
  output logic        start_udivide,
  output logic        stall,
  output logic [31:0] result,
  output logic        wb_valid,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   res_q, res_d;
  logic [1:0]    f3_q, f3_d;     // func3[2] is always 1 for a divide
  logic          start_s_q, start_s_d;
  logic          start_u_q, start_u_d;
  logic          terr_q, terr_d;

  logic        mul_req, div_req, sgn, dz, ovf, fast, launch;
  logic        ok_take, tmo, busy_live;
  logic [31:0] mul_sel, div_sel, fast_res;

  assign mul_req = rv32m & ~func3[2];
  assign div_req = rv32m &  func3[2];
  assign sgn     = ~func3[0];
  assign dz      = (b == 32'h0);
  assign ovf     = sgn & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
  assign fast    = mul_req | (div_req & (dz | ovf));
  assign launch  = div_req & ~dz & ~ovf;

  // The first two BUSY cycles (cnt 0,1) ignore div_ok: the divider may still
  // be holding ok from the previous operation.
  assign ok_take   = div_ok & (cnt_q >= CW'(2));
  assign tmo       = ~ok_take & (cnt_q == CW'(MAX_WAIT - 1));
  assign busy_live = (state_q == S_BUSY) & ~cancel;

  always_comb begin
    unique case (func3[1:0])
      2'b00:   mul_sel = c_mul;
      2'b01:   mul_sel = c_mulh;
      2'b10:   mul_sel = c_mulhsu;
      default: mul_sel = c_mulu;
    endcase
  end

  always_comb begin
    unique case (f3_q)
      2'b00:   div_sel = c_div;
      2'b01:   div_sel = c_divu;
      2'b10:   div_sel = c_rem;
      default: div_sel = c_remu;
    endcase
  end

  // RISC-V fixed answers: x/0 = all ones, x%0 = x; INT_MIN/-1 = INT_MIN, rem 0
  always_comb begin
    if (mul_req)  fast_res = mul_sel;
    else if (dz)  fast_res = func3[1] ? a : 32'hFFFF_FFFF;
    else          fast_res = func3[1] ? 32'h0 : 32'h8000_0000;
  end

  // ---- state register ----
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (launch & ~cancel) state_d = S_BUSY;
      S_BUSY:  if (cancel) state_d = S_IDLE;
               else if (ok_take | tmo) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- outputs ----
  // Gated by clrn so nothing is presented while reset is asserted.
  always_comb begin
    stall    = 1'b0;
    wb_valid = 1'b0;
    result   = 32'h0;
    if (clrn && !cancel) begin
      unique case (state_q)
        S_IDLE: begin
          if (fast) begin
            wb_valid = 1'b1;
            result   = fast_res;
          end else if (launch) begin
            stall = 1'b1;
          end
        end
        S_BUSY:  stall = 1'b1;
        S_DONE: begin
          wb_valid = 1'b1;
          result   = res_q;
        end
        default: ;
      endcase
    end
  end

  // ---- datapath registers ----
  always_comb begin
    cnt_d     = (state_q == S_BUSY && state_d == S_BUSY) ? cnt_q + CW'(1) : '0;
    start_s_d = (state_q == S_IDLE) & (state_d == S_BUSY) &  sgn;
    start_u_d = (state_q == S_IDLE) & (state_d == S_BUSY) & ~sgn;
    f3_d      = (state_q == S_IDLE && state_d == S_BUSY) ? func3[1:0] : f3_q;
    res_d     = res_q;
    if (busy_live && ok_take)  res_d = div_sel;
    else if (busy_live && tmo) res_d = 32'h0;
    terr_d    = terr_q | (busy_live & tmo);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q     <= '0;
      res_q     <= 32'h0;
      f3_q      <= 2'b00;
      start_s_q <= 1'b0;
      start_u_q <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      f3_q      <= f3_d;
      start_s_q <= start_s_d;
      start_u_q <= start_u_d;
      terr_q    <= terr_d;
    end
  end

  assign start_sdivide = start_s_q;
  assign start_udivide = start_u_q;
  assign timeout_err   = terr_q;

endmodule
